// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction prefetch path.
package imem_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned PF_DEPTH_DEFAULT = 4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} pf_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; power-of-two depth, pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   // Storage is cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: one outstanding fetch, results buffered
// in a FIFO for instr_fetch; a redirect flushes and restarts at the target.
module imem_prefetch
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH    = PF_DEPTH_DEFAULT,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   pf_state_t    state;
   pf_state_t    state_next;
   logic [31:0]  fetch_pc;
   logic [31:0]  fetch_pc_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;
   fetch_entry_t wr_entry;
   fetch_entry_t head;

   // A redirect wins over both the push of a returning word and a head pop.
   assign pop         = ~empty & instr_ready & ~redirect;
   assign push        = (state == WAIT) & mem_resp_valid & ~redirect;
   assign count_after = count + CW'(push) - CW'(pop);
   assign wr_entry    = '{pc: fetch_pc - 32'd4, instr: mem_resp_data};

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign instr_valid = ~empty;
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

   // Next-state logic; fetch_pc already points past the word in flight.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      case (state)
         IDLE:    if (!full) state_next = REQ;
         REQ: begin
            if (mem_req_ready) begin
               fetch_pc_next = fetch_pc + 32'd4;
               state_next    = WAIT;
            end
         end
         WAIT:    if (mem_resp_valid) state_next = (count_after < CW'(DEPTH)) ? REQ : IDLE;
         DISCARD: if (mem_resp_valid) state_next = REQ;
         default: state_next = IDLE;
      endcase
      if (redirect) begin
         fetch_pc_next = redirect_pc;
         case (state)
            REQ:           state_next = mem_req_ready ? DISCARD : REQ;
            WAIT, DISCARD: state_next = mem_resp_valid ? REQ : DISCARD;
            default:       state_next = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         fetch_pc      <= RESET_PC;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= RESET_PC;
      end else begin
         state         <= state_next;
         fetch_pc      <= fetch_pc_next;
         mem_req_valid <= (state_next == REQ);
         mem_req_addr  <= fetch_pc_next;
      end
   end

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: memory model and expected-instruction scoreboard
// with directed corner cases followed by randomized traffic and redirects.
module tb_imem_prefetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Knobs: rdy_mode 0=random 1=always 2=never; lat_fix 0=random 1..4;
   // ir_mode 0=random 1=always 2=never.
   int rdy_mode = 1;
   int lat_fix  = 1;
   int ir_mode  = 1;
   int hs_count = 0;
   int fifo_cnt = 0;
   int wait_cnt = 0;
   exp_t q[$];

   logic        busy = 1'b0, rst_stale = 1'b0, red_stale = 1'b0, resp_live_now = 1'b0;
   logic [31:0] paddr = '0, next_req = RESET_PC;
   logic        chk_rst = 1'b0, chk_rel = 1'b0, chk_redir = 1'b0, chk_live = 1'b0;
   logic        chk_hold = 1'b0, last_reset = 1'b0;
   logic [31:0] chk_pc = '0, hold_addr = '0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, 32'(act), 32'(exp));
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {~a[15:0] ^ 16'h1234, a[15:0] ^ a[31:16]};
   endfunction

   // Memory model: one request at a time, in-order response after lat cycles.
   initial begin : mem_model
      logic hs, live;
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (chk_rst) begin
            chk1("rst_req_valid", mem_req_valid, 1'b0);
            chk1("rst_instr_valid", instr_valid, 1'b0);
            chk32("rst_req_addr", mem_req_addr, RESET_PC);
            chk32("rst_instr", instr, 32'h0);
            chk32("rst_instr_pc", instr_pc, 32'h0);
         end
         if (chk_rel)   chk1("req_after_release", mem_req_valid, 1'b1);
         if (chk_redir) begin
            chk1("redir_req_valid", mem_req_valid, 1'b1);
            chk32("redir_req_addr", mem_req_addr, chk_pc);
         end
         if (chk_live)  chk1("resp_to_instr_valid", instr_valid, 1'b1);
         if (chk_hold) begin
            chk1("hold_req_valid", mem_req_valid, 1'b1);
            chk32("hold_req_addr", mem_req_addr, hold_addr);
         end
         if (busy && !rst_stale) chk1("one_outstanding", mem_req_valid, 1'b0);

         mem_resp_valid = 1'b0;
         resp_live_now  = 1'b0;
         if (busy) begin
            if (wait_cnt <= 1) begin
               live           = reset && !redirect && !red_stale && !rst_stale;
               mem_resp_valid = 1'b1;
               mem_resp_data  = (red_stale || rst_stale) ? 32'hDEAD : mdata(paddr);
               resp_live_now  = live;
               busy           = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
         if (!reset && busy)  rst_stale = 1'b1;
         if (redirect && busy) red_stale = 1'b1;

         if (busy)               mem_req_ready = 1'b0;
         else if (rdy_mode == 1) mem_req_ready = 1'b1;
         else if (rdy_mode == 2) mem_req_ready = 1'b0;
         else                    mem_req_ready = ($urandom_range(0, 99) < 70);

         hs = mem_req_valid && mem_req_ready && reset;
         if (hs) begin
            chk32("req_addr", mem_req_addr, next_req);
            if (!redirect) begin
               e.pc   = mem_req_addr;
               e.data = mdata(mem_req_addr);
               q.push_back(e);
            end
            chk1("inflight_bound", q.size() <= int'(DEPTH), 1'b1);
            next_req  = mem_req_addr + 32'd4;
            paddr     = mem_req_addr;
            busy      = 1'b1;
            wait_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
            red_stale = redirect;
            rst_stale = 1'b0;
            hs_count++;
         end
         if (!reset)        next_req = RESET_PC;
         else if (redirect) next_req = redirect_pc;

         chk_rst    = !reset;
         chk_rel    = reset && !last_reset;
         last_reset = reset;
         chk_redir  = redirect && reset && !(busy && !rst_stale);
         chk_pc     = redirect_pc;
         chk_live   = resp_live_now;
         chk_hold   = mem_req_valid && !mem_req_ready && !redirect && reset;
         hold_addr  = mem_req_addr;
      end
   end

   // Monitor: every pop must match the oldest expected {pc, instr}.
   initial begin : monitor
      exp_t e;
      logic pop;
      forever begin
         @(negedge clk); #2;
         chk1("instr_valid", instr_valid, fifo_cnt != 0);
         pop = instr_valid && instr_ready;
         if (!reset || redirect) begin
            q.delete();
            fifo_cnt = 0;
         end else begin
            if (pop) begin
               chk1("pop_has_expected", q.size() != 0, 1'b1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk32("instr_pc", instr_pc, e.pc);
                  chk32("instr", instr, e.data);
               end
            end
            fifo_cnt = fifo_cnt + (resp_live_now ? 1 : 0) - (pop ? 1 : 0);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      redirect = 1'b0;
      if (ir_mode == 0) instr_ready = 1'($urandom_range(0, 1));
      else              instr_ready = (ir_mode == 1);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      tick();
      reset = 1'b0;
      run(n - 1);
      tick();
      reset    = 1'b1;
      hs_count = 0;
   endtask

   initial begin : stim
      int g;
      logic [31:0] r;

      // Reset release with a zero-wait memory and a free-running consumer.
      run(3);
      tick();
      reset = 1'b1;
      hs_count = 0;
      run(20);

      // Stalled consumer: exactly DEPTH words buffered, then drain.
      ir_mode = 2;
      do_reset(2);
      run(30);
      chk32("stall_accepted", 32'(hs_count), 32'd4);
      chk1("stall_req_idle", mem_req_valid, 1'b0);
      chk32("stall_fifo_cnt", 32'(fifo_cnt), 32'd4);
      chk32("stall_head_pc", instr_pc, 32'h0);
      ir_mode = 1;
      run(20);

      // Redirect while waiting for a response.
      lat_fix = 3;
      g = 0;
      while (!(busy && !red_stale && !rst_stale && wait_cnt >= 2) && g < 100) begin tick(); g++; end
      chk1("wait_state_reached", g < 100, 1'b1);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick();
      chk1("redir_wait_flushed", instr_valid, 1'b0);
      run(12);

      // Redirect coinciding with a response and a pop.
      lat_fix = 2;
      ir_mode = 2;
      g = 0;
      while (!(fifo_cnt >= 1 && busy && wait_cnt == 1 && !red_stale && !rst_stale) && g < 100) begin
         tick(); g++;
      end
      chk1("resp_cycle_reached", g < 100, 1'b1);
      ir_mode = 1;
      instr_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      chk1("redir_resp_no_valid", instr_valid, 1'b0);
      chk32("redir_resp_addr", mem_req_addr, 32'h200);
      run(10);

      // Unaccepted request retargeted by a redirect, then address wrap.
      rdy_mode = 2;
      g = 0;
      while (!mem_req_valid && g < 50) begin tick(); g++; end
      chk1("req_pending_reached", g < 50, 1'b1);
      run(3);
      redirect = 1'b1;
      redirect_pc = 32'h40;
      run(3);
      chk32("retarget_hold_addr", mem_req_addr, 32'h40);
      rdy_mode = 1;
      run(10);
      tick();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      run(12);

      // Reset while waiting with two entries buffered.
      lat_fix = 3;
      ir_mode = 2;
      g = 0;
      while (!(fifo_cnt == 2 && busy && !red_stale && !rst_stale) && g < 100) begin tick(); g++; end
      chk1("two_buffered_reached", g < 100, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ir_mode = 1;
      run(20);

      // Randomized traffic with redirects and occasional resets.
      lat_fix  = 0;
      rdy_mode = 0;
      ir_mode  = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!reset) begin
            reset = 1'b1;
         end else if ($urandom_range(0, 599) == 0) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 29) == 0) begin
            r = $urandom();
            redirect = 1'b1;
            redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00};
         end
      end
      tick();
      reset = 1'b1;
      ir_mode = 1;
      run(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
